// File: rtl/exers.sv
// exers: ALU/branch reservation station with tag wakeup from the writeback bus
// and an age matrix so the oldest fully-ready entry issues into a registered slot.
module exers #(
    parameter int DEPTH = 8,
    parameter int TAGW  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rename_exers_write,
    input  logic [4:0]  rename_op,
    input  logic [6:0]  rename_robid,
    input  logic [5:0]  rename_rd,
    input  logic        rename_op1ready,
    input  logic [31:0] rename_op1,
    input  logic        rename_op2ready,
    input  logic [31:0] rename_op2,
    input  logic [31:0] rename_imm,
    output logic        exers_stall,
    input  logic        wb_valid,
    input  logic [6:0]  wb_robid,
    input  logic [31:0] wb_result,
    input  logic        rob_flush,
    input  logic        alu_stall,
    output logic        exers_issue_valid,
    output logic [4:0]  exers_issue_op,
    output logic [6:0]  exers_issue_robid,
    output logic [5:0]  exers_issue_rd,
    output logic [31:0] exers_issue_op1,
    output logic [31:0] exers_issue_op2,
    output logic [31:0] exers_issue_imm
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q, valid_d, rdy1_q, rdy2_q, wake1, wake2, cand, sel;
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [4:0]       op_q [DEPTH];
    logic [6:0]       robid_q [DEPTH];
    logic [5:0]       rd_q [DEPTH];
    logic [31:0]      imm_q [DEPTH];
    logic [31:0]      val1_q [DEPTH];
    logic [31:0]      val2_q [DEPTH];
    logic [IW-1:0]    free_idx, sel_idx;
    logic             wr, load, any_cand, in1_wake, in2_wake;

    assign exers_stall = &valid_q;
    assign wr          = rename_exers_write & ~exers_stall & ~rob_flush;
    assign load        = ~exers_issue_valid | ~alu_stall;
    assign cand        = valid_q & rdy1_q & rdy2_q;
    assign any_cand    = |cand;
    assign in1_wake    = wb_valid & ~rename_op1ready & (rename_op1[TAGW-1:0] == wb_robid[TAGW-1:0]);
    assign in2_wake    = wb_valid & ~rename_op2ready & (rename_op2[TAGW-1:0] == wb_robid[TAGW-1:0]);

    // age_q[j][i] set means entry j is older than entry i
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        sel      = '0;
        wake1    = '0;
        wake2    = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid_q[i]) free_idx = IW'(i);
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = valid_q[i] & ~rdy1_q[i] & wb_valid & (val1_q[i][TAGW-1:0] == wb_robid[TAGW-1:0]);
            wake2[i] = valid_q[i] & ~rdy2_q[i] & wb_valid & (val2_q[i][TAGW-1:0] == wb_robid[TAGW-1:0]);
            sel[i]   = cand[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && cand[j] && age_q[j][i]) sel[i] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++)
            if (sel[i]) sel_idx = IW'(i);
        valid_d = valid_q;
        if (load && any_cand) valid_d[sel_idx] = 1'b0;
        if (wr) valid_d[free_idx] = 1'b1;
        if (rob_flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i]   <= '0;
                op_q[i]    <= '0;
                robid_q[i] <= '0;
                rd_q[i]    <= '0;
                imm_q[i]   <= '0;
                val1_q[i]  <= '0;
                val2_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wake1[i]) begin
                    val1_q[i] <= wb_result;
                    rdy1_q[i] <= 1'b1;
                end
                if (wake2[i]) begin
                    val2_q[i] <= wb_result;
                    rdy2_q[i] <= 1'b1;
                end
                if (wr) age_q[i][free_idx] <= valid_q[i];
                if (wr && free_idx == IW'(i)) begin
                    age_q[i]   <= '0;
                    op_q[i]    <= rename_op;
                    robid_q[i] <= rename_robid;
                    rd_q[i]    <= rename_rd;
                    imm_q[i]   <= rename_imm;
                    rdy1_q[i]  <= rename_op1ready | in1_wake;
                    val1_q[i]  <= in1_wake ? wb_result : rename_op1;
                    rdy2_q[i]  <= rename_op2ready | in2_wake;
                    val2_q[i]  <= in2_wake ? wb_result : rename_op2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exers_issue_valid <= 1'b0;
            exers_issue_op    <= '0;
            exers_issue_robid <= '0;
            exers_issue_rd    <= '0;
            exers_issue_op1   <= '0;
            exers_issue_op2   <= '0;
            exers_issue_imm   <= '0;
        end else if (rob_flush) begin
            exers_issue_valid <= 1'b0;
        end else if (load) begin
            exers_issue_valid <= any_cand;
            if (any_cand) begin
                exers_issue_op    <= op_q[sel_idx];
                exers_issue_robid <= robid_q[sel_idx];
                exers_issue_rd    <= rd_q[sel_idx];
                exers_issue_op1   <= val1_q[sel_idx];
                exers_issue_op2   <= val2_q[sel_idx];
                exers_issue_imm   <= imm_q[sel_idx];
            end
        end
    end
endmodule
